// File: rtl/dpram_tx_pkg.sv
// Shared types and constants for the DPRAM byte transmitter.
package dpram_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_RD_WAIT,
    S_BYTES,
    S_DONE
  } state_t;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned LEN_WIDTH  = 16;
  localparam int unsigned CNT_WIDTH  = 17;
  localparam int unsigned HDR_BYTES  = 3;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Header packed MSB-first into a word so the serializer can send it like data.
  function automatic logic [WORD_WIDTH-1:0] hdr_word(input logic [BYTE_WIDTH-1:0] sync,
                                                     input logic [LEN_WIDTH-1:0]  len);
    return {sync, len, 8'h00};
  endfunction

endpackage

// File: rtl/dpram_byte_tx_if.sv
// Valid/ready byte stream toward the comms link.
interface dpram_byte_tx_if;
  import dpram_tx_pkg::*;

  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/word_byte_serializer.sv
// 32->8 output stage: sends bytes 0..last_idx of a loaded word MSB-first,
// holding data/last stable under backpressure.
module word_byte_serializer
  import dpram_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [1:0]            last_idx,
  input  logic                  last_frame,
  output logic                  word_done_c,
  dpram_byte_tx_if.master       tx
);

  logic [WORD_WIDTH-BYTE_WIDTH-1:0] shreg;
  logic [1:0]                       idx;
  logic [1:0]                       idx_next_c;
  logic [1:0]                       last_idx_q;
  logic                             last_frame_q;
  logic                             xfer_c;

  assign xfer_c      = tx.tx_valid && tx.tx_ready;
  assign word_done_c = xfer_c && (idx == last_idx_q);
  assign idx_next_c  = idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx.tx_data   <= '0;
      tx.tx_valid  <= 1'b0;
      tx.tx_last   <= 1'b0;
      shreg        <= '0;
      idx          <= '0;
      last_idx_q   <= '0;
      last_frame_q <= 1'b0;
    end else if (load) begin
      tx.tx_data   <= word[WORD_WIDTH-1 -: BYTE_WIDTH];
      shreg        <= word[WORD_WIDTH-BYTE_WIDTH-1:0];
      idx          <= '0;
      last_idx_q   <= last_idx;
      last_frame_q <= last_frame;
      tx.tx_valid  <= 1'b1;
      tx.tx_last   <= last_frame && (last_idx == 2'd0);
    end else if (xfer_c) begin
      if (word_done_c) begin
        tx.tx_valid <= 1'b0;
        tx.tx_last  <= 1'b0;
      end else begin
        tx.tx_data <= shreg[WORD_WIDTH-BYTE_WIDTH-1 -: BYTE_WIDTH];
        shreg      <= {shreg[WORD_WIDTH-2*BYTE_WIDTH-1:0], 8'h00};
        idx        <= idx_next_c;
        tx.tx_last <= last_frame_q && (idx_next_c == last_idx_q);
      end
    end
  end

endmodule

// File: rtl/dpram_byte_tx.sv
// Streams a filled DPRAM as a framed byte stream: sync, 16-bit word count,
// then each word big-endian; busy covers the whole frame.
module dpram_byte_tx
  import dpram_tx_pkg::*;
#(
  parameter int unsigned          P_DPRAM_ADR_WIDTH = 10,
  parameter logic [BYTE_WIDTH-1:0] P_SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cfg_mode,
  input  logic                         dpram_run,
  input  logic [LEN_WIDTH-1:0]         dpram_len,
  output logic                         dpram_busy,
  output logic                         dpram_mode,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [WORD_WIDTH-1:0]        dpram_rd_data,
  dpram_byte_tx_if.master              tx
);

  localparam int unsigned ADR_W = P_DPRAM_ADR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(2 ** ADR_W);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [ADR_W-1:0]     addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 mode_q, mode_d;

  logic [CNT_WIDTH-1:0]  len_ext_c;
  logic [CNT_WIDTH-1:0]  clamp_c;
  logic                  load_c;
  logic [WORD_WIDTH-1:0] load_word_c;
  logic [1:0]            load_last_idx_c;
  logic                  load_last_c;
  logic                  word_done_c;

  assign len_ext_c = CNT_WIDTH'(dpram_len);
  assign clamp_c   = (len_ext_c > MAX_WORDS) ? MAX_WORDS : len_ext_c;

  // State and frame bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and serializer load control; rem counts words still to send.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    addr_d          = addr_q;
    busy_d          = busy_q;
    mode_d          = mode_q;
    load_c          = 1'b0;
    load_word_c     = '0;
    load_last_idx_c = '0;
    load_last_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        mode_d = cfg_mode;
        if (dpram_run && en) begin
          busy_d          = 1'b1;
          rem_d           = clamp_c;
          addr_d          = '0;
          load_c          = 1'b1;
          load_word_c     = hdr_word(P_SYNC_BYTE, clamp_c[LEN_WIDTH-1:0]);
          load_last_idx_c = 2'(HDR_BYTES - 1);
          load_last_c     = (clamp_c == '0);
          state_d         = S_HDR;
        end
      end
      S_HDR: begin
        if (word_done_c) state_d = (rem_q == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        load_c          = 1'b1;
        load_word_c     = dpram_rd_data;
        load_last_idx_c = 2'(WORD_BYTES - 1);
        load_last_c     = (rem_q == CNT_WIDTH'(1));
        state_d         = S_BYTES;
      end
      S_BYTES: begin
        if (word_done_c) begin
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADR_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  word_byte_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (load_c),
    .word        (load_word_c),
    .last_idx    (load_last_idx_c),
    .last_frame  (load_last_c),
    .word_done_c (word_done_c),
    .tx          (tx)
  );

  assign dpram_busy    = busy_q;
  assign dpram_mode    = mode_q;
  assign dpram_rd_addr = addr_q;

endmodule

// File: tb/tb_dpram_byte_tx.sv
// Bench for dpram_byte_tx: frames checked against a byte-list model built
// from the DPRAM contents and the clamped length.
module tb_dpram_byte_tx;

  localparam int unsigned ADR_W = 10;
  localparam int unsigned DEPTH = 1 << ADR_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_mode = 1'b0;
  logic             dpram_run = 1'b0;
  logic [15:0]      dpram_len = '0;
  logic             dpram_busy;
  logic             dpram_mode;
  logic [ADR_W-1:0] dpram_rd_addr;
  logic [31:0]      dpram_rd_data = '0;

  dpram_byte_tx_if tx ();

  dpram_byte_tx #(.P_DPRAM_ADR_WIDTH(ADR_W), .P_SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_mode      (cfg_mode),
    .dpram_run     (dpram_run),
    .dpram_len     (dpram_len),
    .dpram_busy    (dpram_busy),
    .dpram_mode    (dpram_mode),
    .dpram_rd_addr (dpram_rd_addr),
    .dpram_rd_data (dpram_rd_data),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  // Synchronous-read DPRAM: data one cycle after the address.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) dpram_rd_data <= mem[dpram_rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stream monitor: captures transfers, counts busy cycles, checks stall stability.
  logic [8:0] cap [$];
  int         busy_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  bit         bp_on = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx.tx_valid), 32'(1));
        chk("hold_data", 32'(tx.tx_data), 32'(prev_data));
        chk("hold_last", 32'(tx.tx_last), 32'(prev_last));
      end
      if (tx.tx_valid && tx.tx_ready) cap.push_back({tx.tx_last, tx.tx_data});
      if (dpram_busy) busy_cnt++;
      prev_stall = tx.tx_valid && !tx.tx_ready;
      prev_data  = tx.tx_data;
      prev_last  = tx.tx_last;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_on) tx.tx_ready = 1'($urandom_range(0, 1));
  end

  // Reference frame: sync, clamped count MSB first, words big-endian, last on final byte.
  logic [8:0] exp_q [$];

  task automatic build_exp(input int len);
    int          n;
    logic [15:0] n16;
    logic [8:0]  t;
    n   = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    n16 = 16'(n);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, n16[15:8]});
    exp_q.push_back({1'b0, n16[7:0]});
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({1'b0, 8'(mem[k] >> (24 - 8 * b))});
    t = exp_q[exp_q.size() - 1];
    t[8] = 1'b1;
    exp_q[exp_q.size() - 1] = t;
  endtask

  task automatic pulse_run(input int len);
    @(posedge clk);
    #1;
    dpram_len = 16'(len);
    dpram_run = 1'b1;
    @(posedge clk);
    #1;
    dpram_run = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!dpram_busy) break;
    end
    chk({tag, "_idle"}, 32'(dpram_busy), 32'(0));
  endtask

  task automatic check_frame(input string tag, input int base);
    int got;
    got = cap.size() - base;
    chk({tag, "_nbytes"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap[base + i]), 32'(exp_q[i]));
      if (cap[base + i] !== exp_q[i]) break;
    end
  endtask

  // Full frame with ready high, including first-beat and busy-duration timing.
  task automatic run_frame(input string tag, input int len);
    int base, bc0, n;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    build_exp(len);
    base = cap.size();
    bc0  = busy_cnt;
    pulse_run(len);
    chk({tag, "_busy_t1"}, 32'(dpram_busy), 32'(1));
    chk({tag, "_valid_t1"}, 32'(tx.tx_valid), 32'(1));
    chk({tag, "_sync_t1"}, 32'(tx.tx_data), 32'hA5);
    wait_idle(tag);
    check_frame(tag, base);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - bc0), 32'(4 + 6 * n));
  endtask

  initial begin
    int base;
    int len;
    logic any_last;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    tx.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dpram_busy), 32'(0));
    chk("rst_valid", 32'(tx.tx_valid), 32'(0));
    chk("rst_last", 32'(tx.tx_last), 32'(0));
    chk("rst_data", 32'(tx.tx_data), 32'(0));
    chk("rst_addr", 32'(dpram_rd_addr), 32'(0));
    chk("rst_mode", 32'(dpram_mode), 32'(0));
    rst = 1'b0;
    en  = 1'b1;

    // Basic two-word frame
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    run_frame("basic", 2);

    // Empty frame: header only
    run_frame("empty", 0);

    // Random short frames
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      len = int'($urandom_range(1, 12));
      run_frame($sformatf("rand%0d", r), len);
    end

    // Backpressure on the basic frame
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    build_exp(2);
    base  = cap.size();
    bp_on = 1'b1;
    pulse_run(2);
    wait_idle("bp");
    bp_on = 1'b0;
    @(posedge clk);
    #2;
    tx.tx_ready = 1'b1;
    check_frame("bp", base);

    // Backpressure on a longer random frame
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    build_exp(9);
    base  = cap.size();
    bp_on = 1'b1;
    pulse_run(9);
    wait_idle("bp9");
    bp_on = 1'b0;
    @(posedge clk);
    #2;
    tx.tx_ready = 1'b1;
    check_frame("bp9", base);

    // Clamp to DPRAM depth with a second run ignored mid-frame
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    build_exp(16'h0500);
    base = cap.size();
    pulse_run(16'h0500);
    repeat (100) @(negedge clk);
    pulse_run(3);
    wait_idle("clamp");
    check_frame("clamp", base);
    repeat (20) @(negedge clk);
    chk("clamp_no_second", 32'(cap.size() - base), 32'(3 + 4 * DEPTH));
    chk("clamp_busy_after", 32'(dpram_busy), 32'(0));

    // Run with enable low is ignored
    en   = 1'b0;
    base = cap.size();
    pulse_run(2);
    chk("en0_busy", 32'(dpram_busy), 32'(0));
    repeat (10) @(negedge clk);
    chk("en0_busy_late", 32'(dpram_busy), 32'(0));
    chk("en0_nbytes", 32'(cap.size() - base), 32'(0));
    en = 1'b1;

    // Mode follows cfg_mode only while idle
    cfg_mode = 1'b1;
    repeat (2) @(negedge clk);
    chk("mode_idle", 32'(dpram_mode), 32'(1));
    build_exp(3);
    base = cap.size();
    pulse_run(3);
    repeat (4) @(negedge clk);
    cfg_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("mode_mid", 32'(dpram_mode), 32'(1));
    wait_idle("mode");
    chk("mode_at_idle", 32'(dpram_mode), 32'(1));
    repeat (2) @(negedge clk);
    chk("mode_after", 32'(dpram_mode), 32'(0));
    check_frame("mode", base);

    // Asynchronous reset during word 1, then a fresh frame
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    base = cap.size();
    pulse_run(2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cap.size() >= base + 8) break;
    end
    chk("rst_mid_reached", 32'(cap.size() - base), 32'(8));
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_busy", 32'(dpram_busy), 32'(0));
    chk("rstm_valid", 32'(tx.tx_valid), 32'(0));
    chk("rstm_last", 32'(tx.tx_last), 32'(0));
    chk("rstm_data", 32'(tx.tx_data), 32'(0));
    chk("rstm_addr", 32'(dpram_rd_addr), 32'(0));
    any_last = 1'b0;
    for (int i = base; i < cap.size(); i++) any_last = any_last | cap[i][8];
    chk("rstm_no_last", 32'(any_last), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame("after_rst", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
